// File: rtl/codec_i2c_arbiter.sv
// Two-port arbiter in front of the codec I2C register-write master.
// Round-robin grant, one write per grant, retry on master error, per-attempt timeout.
module codec_i2c_arbiter #(
  parameter int unsigned RETRY_MAX   = 2,
  parameter int unsigned TO_W        = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       audio_clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic [7:0] data0,
  output logic       ack0,
  output logic       err0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       err1,
  output logic       mst_write,
  output logic [7:0] mst_subaddr,
  output logic [7:0] mst_data,
  input  logic       mst_ready,
  input  logic       mst_error,
  output logic       busy,
  output logic       grant
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitAcc  = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StResp     = 3'd4;

  localparam int unsigned RetryW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RetryW-1:0] RetryLast = RetryW'(RETRY_MAX);
  localparam logic [TO_W-1:0]   ToLast    = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [7:0]        sub_q, sub_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic              pick;

  // On a tie the port that was not served last wins.
  assign pick = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    retry_d = retry_q;
    to_d    = to_q;
    sub_d   = sub_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (mst_ready && (req0 || req1)) begin
          grant_d = pick;
          sub_d   = pick ? addr1 : addr0;
          data_d  = pick ? data1 : data0;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        to_d    = '0;
        state_d = StWaitAcc;
      end
      StWaitAcc: begin
        to_d = to_q + TO_W'(1);
        if (to_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (!mst_ready) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        to_d = to_q + TO_W'(1);
        // Timeouts go straight to the response and are never retried.
        if (to_q == ToLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (mst_ready) begin
          if (mst_error && (retry_q < RetryLast)) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StIssue;
          end else begin
            err_d   = mst_error;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge audio_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      retry_q <= '0;
      to_q    <= '0;
      sub_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      sub_q   <= sub_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign mst_write   = (state_q == StIssue);
  assign mst_subaddr = sub_q;
  assign mst_data    = data_q;
  assign grant       = grant_q;
  assign ack0        = (state_q == StResp) && !grant_q;
  assign ack1        = (state_q == StResp) && grant_q;
  assign err0        = ack0 && err_q;
  assign err1        = ack1 && err_q;

endmodule

// File: tb/tb_codec_i2c_arbiter.sv
// Directed bench for codec_i2c_arbiter: behavioural I2C master plus a scoreboard of
// expected writes and acks.
module tb_codec_i2c_arbiter;

  localparam int unsigned RetryMax   = 2;
  localparam int unsigned TimeoutCyc = 16;

  typedef struct packed {
    logic       port;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct packed {
    logic port;
    logic err;
  } ack_t;

  logic       audio_clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, data0 = '0, addr1 = '0, data1 = '0;
  logic       ack0, err0, ack1, err1, mst_write, busy, grant;
  logic [7:0] mst_subaddr, mst_data;
  logic       mst_ready;
  logic       mst_error = 1'b0;
  logic       m_ready = 1'b1, m_hold = 1'b0, m_never = 1'b0;
  int         m_done_dly = 8;
  bit         m_errs[$];

  wr_t  exp_wr[$];
  ack_t exp_ack[$];
  wr_t  ew;
  ack_t ea;
  int   checks = 0, errors = 0;
  int   write_cnt = 0, ack_cnt = 0;

  assign mst_ready = m_ready & ~m_hold;

  codec_i2c_arbiter #(
    .RETRY_MAX  (RetryMax),
    .TO_W       (16),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .audio_clk  (audio_clk),
    .reset      (reset),
    .req0       (req0),
    .addr0      (addr0),
    .data0      (data0),
    .ack0       (ack0),
    .err0       (err0),
    .req1       (req1),
    .addr1      (addr1),
    .data1      (data1),
    .ack1       (ack1),
    .err1       (err1),
    .mst_write  (mst_write),
    .mst_subaddr(mst_subaddr),
    .mst_data   (mst_data),
    .mst_ready  (mst_ready),
    .mst_error  (mst_error),
    .busy       (busy),
    .grant      (grant)
  );

  always #5 audio_clk = ~audio_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int t;
    t = 0;
    while (ack_cnt < n && t < budget) begin
      @(negedge audio_clk);
      t++;
    end
    check("ack_wait", (ack_cnt >= n), 1);
  endtask

  // Master model: accepts 2 cycles after the strobe, completes m_done_dly cycles later.
  initial begin
    forever begin
      @(negedge audio_clk);
      if (mst_write === 1'b1 && !m_never) begin
        repeat (2) @(negedge audio_clk);
        m_ready = 1'b0;
        repeat (m_done_dly) @(negedge audio_clk);
        mst_error = (m_errs.size() > 0) ? m_errs.pop_front() : 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  // Scoreboard: compare every strobe and every ack against the queued expectations.
  always @(posedge audio_clk) begin
    #1;
    if (mst_write === 1'b1) begin
      write_cnt++;
      check("wr_expected", (exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) begin
        ew = exp_wr.pop_front();
        check("wr_grant", grant, ew.port);
        check("wr_subaddr", mst_subaddr, ew.a);
        check("wr_data", mst_data, ew.d);
      end
    end
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      ack_cnt++;
      check("ack_excl", (ack0 & ack1), 0);
      check("ack_expected", (exp_ack.size() != 0), 1);
      if (exp_ack.size() != 0) begin
        ea = exp_ack.pop_front();
        check("ack_port", ack1, ea.port);
        check("ack_err", ack1 ? err1 : err0, ea.err);
        check("ack_other_err", ack1 ? err0 : err1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, w, t;
    #1;
    check("reset_outputs",
          {ack0, err0, ack1, err1, mst_write, busy, grant, mst_subaddr, mst_data}, 0);
    repeat (3) @(negedge audio_clk);
    reset = 1'b0;
    @(negedge audio_clk);
    check("idle_after_reset", busy, 0);

    // Tie after reset: port 0 first, then strict alternation.
    a = ack_cnt;
    w = write_cnt;
    req0 = 1'b1; addr0 = 8'h11; data0 = 8'hA1;
    req1 = 1'b1; addr1 = 8'h22; data1 = 8'hB2;
    exp_wr.push_back('{1'b0, 8'h11, 8'hA1}); exp_ack.push_back('{1'b0, 1'b0});
    exp_wr.push_back('{1'b1, 8'h22, 8'hB2}); exp_ack.push_back('{1'b1, 1'b0});
    exp_wr.push_back('{1'b0, 8'h13, 8'hA3}); exp_ack.push_back('{1'b0, 1'b0});
    exp_wr.push_back('{1'b1, 8'h24, 8'hB4}); exp_ack.push_back('{1'b1, 1'b0});
    wait_acks(a + 1, 100);
    addr0 = 8'h13; data0 = 8'hA3;
    wait_acks(a + 2, 100);
    addr1 = 8'h24; data1 = 8'hB4;
    wait_acks(a + 3, 100);
    req0 = 1'b0;
    wait_acks(a + 4, 100);
    req1 = 1'b0;
    check("tie_write_count", write_cnt - w, 4);

    // Single write with one-cycle request-to-strobe latency.
    @(negedge audio_clk);
    a = ack_cnt;
    req0 = 1'b1; addr0 = 8'h15; data0 = 8'h01;
    exp_wr.push_back('{1'b0, 8'h15, 8'h01}); exp_ack.push_back('{1'b0, 1'b0});
    @(negedge audio_clk);
    check("single_latency", mst_write, 1);
    wait_acks(a + 1, 100);
    req0 = 1'b0;
    @(negedge audio_clk);
    check("single_busy_low", busy, 0);

    // Master busy: nothing issues until ready, then port 1 strobes the next cycle.
    a = ack_cnt;
    w = write_cnt;
    m_hold = 1'b1;
    req1 = 1'b1; addr1 = 8'h33; data1 = 8'h80;
    exp_wr.push_back('{1'b1, 8'h33, 8'h80}); exp_ack.push_back('{1'b1, 1'b0});
    repeat (6) @(negedge audio_clk);
    check("hold_no_write", write_cnt - w, 0);
    check("hold_idle", busy, 0);
    m_hold = 1'b0;
    @(negedge audio_clk);
    check("ready_write", mst_write, 1);
    check("ready_grant", grant, 1);
    wait_acks(a + 1, 100);
    req1 = 1'b0;

    // Retry recovering on the third attempt.
    @(negedge audio_clk);
    a = ack_cnt;
    w = write_cnt;
    m_errs.push_back(1'b1); m_errs.push_back(1'b1); m_errs.push_back(1'b0);
    req0 = 1'b1; addr0 = 8'h2A; data0 = 8'h5C;
    repeat (3) exp_wr.push_back('{1'b0, 8'h2A, 8'h5C});
    exp_ack.push_back('{1'b0, 1'b0});
    wait_acks(a + 1, 200);
    req0 = 1'b0;
    check("retry_ok_writes", write_cnt - w, 3);

    // Retry exhausted: error reported after three attempts.
    @(negedge audio_clk);
    a = ack_cnt;
    w = write_cnt;
    m_errs.push_back(1'b1); m_errs.push_back(1'b1); m_errs.push_back(1'b1);
    req0 = 1'b1; addr0 = 8'h07; data0 = 8'hE3;
    repeat (3) exp_wr.push_back('{1'b0, 8'h07, 8'hE3});
    exp_ack.push_back('{1'b0, 1'b1});
    wait_acks(a + 1, 200);
    req0 = 1'b0;
    check("retry_fail_writes", write_cnt - w, 3);

    // Timeout: master never accepts; ack 16 cycles after entering the accept wait.
    @(negedge audio_clk);
    w = write_cnt;
    m_never = 1'b1;
    req0 = 1'b1; addr0 = 8'h44; data0 = 8'h99;
    exp_wr.push_back('{1'b0, 8'h44, 8'h99}); exp_ack.push_back('{1'b0, 1'b1});
    @(negedge audio_clk);
    check("timeout_issue", mst_write, 1);
    t = 0;
    while (ack0 !== 1'b1 && t < 40) begin
      @(negedge audio_clk);
      t++;
    end
    check("timeout_cycles", t, TimeoutCyc + 1);
    req0 = 1'b0;
    m_never = 1'b0;
    repeat (3) @(negedge audio_clk);
    check("timeout_no_retry", write_cnt - w, 1);

    // Reset mid-transfer: last served is port 0, so port 1 wins this tie.
    req0 = 1'b1; addr0 = 8'h40; data0 = 8'h41;
    req1 = 1'b1; addr1 = 8'h50; data1 = 8'h51;
    exp_wr.push_back('{1'b1, 8'h50, 8'h51});
    @(negedge audio_clk);
    check("pre_reset_issue", mst_write, 1);
    repeat (4) @(negedge audio_clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs",
          {ack0, err0, ack1, err1, mst_write, busy, grant, mst_subaddr, mst_data}, 0);
    repeat (2) @(negedge audio_clk);
    reset = 1'b0;
    a = ack_cnt;
    exp_wr.push_back('{1'b0, 8'h40, 8'h41}); exp_ack.push_back('{1'b0, 1'b0});
    t = 0;
    while (mst_write !== 1'b1 && t < 20) begin
      @(negedge audio_clk);
      t++;
    end
    check("restart_delay", t, 5);
    wait_acks(a + 1, 100);
    exp_wr.push_back('{1'b1, 8'h50, 8'h51}); exp_ack.push_back('{1'b1, 1'b0});
    req0 = 1'b0;
    wait_acks(a + 2, 100);
    req1 = 1'b0;

    repeat (5) @(negedge audio_clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("ack_queue_empty", exp_ack.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
